// File: rtl/obstacle_scheduler.sv
// obstacle_pkg / obstacle_scheduler
//
// Sequences a pool of SLOTS obstacle instances for the runner game. It decides
// when a new obstacle spawns from the newest obstacle's position, width and
// gap. It picks the obstacle type and limits runs of the same type. It starts
// the lowest free slot and holds that slot's type while the slot is busy. It
// also forwards the owning slot's denominator to the shared gap divider.
//
// Handshake: start[k] is a level, not a pulse. It rises one cycle after the
// spawn decision and stays high through the next update cycle, which is the
// cycle in which slot k consumes it. It clears on the cycle after that update.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   game_start       pulse: leave IDLE and begin scheduling
//   update           one-cycle frame tick
//   crash            freeze scheduling until rst
//   speed            current speed, x1024 fixed point
//   rnd              free-running random value (rnd[1:0] used)
//   slot_busy        per-slot "not WAITING" flags
//   slot_x_pos       per-slot signed x position (11 bit each)
//   slot_width       per-slot width (10 bit each)
//   slot_gap         per-slot gap (11 bit each)
//   slot_denom       per-slot divider denominator (11 bit each)
//   start            per-slot start level, at most one bit set
//   slot_typ         per-slot type_t (3 bit each)
//   div_denom        denominator of the current divider owner
//   newest           index of the most recently started slot
//   dbg_state        current FSM state, for observation

package obstacle_pkg;
  typedef enum logic [2:0] {
    NONE         = 3'd0,
    CACTUS_SMALL = 3'd1,
    CACTUS_LARGE = 3'd2,
    PTERODACTYL  = 3'd3
  } type_t;
endpackage

module obstacle_scheduler #(
  parameter int SLOTS           = 3,
  parameter int MAX_DUP         = 2,
  parameter int GAME_WIDTH      = 640,
  parameter int PTERO_MIN_SPEED = 8704
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                game_start,
  input  logic                update,
  input  logic                crash,
  input  logic [14:0]         speed,
  input  logic [15:0]         rnd,
  input  logic [SLOTS-1:0]    slot_busy,
  input  logic [SLOTS*11-1:0] slot_x_pos,
  input  logic [SLOTS*10-1:0] slot_width,
  input  logic [SLOTS*11-1:0] slot_gap,
  input  logic [SLOTS*11-1:0] slot_denom,
  output logic [SLOTS-1:0]    start,
  output logic [SLOTS*3-1:0]  slot_typ,
  output logic [10:0]         div_denom,
  output logic [1:0]          newest,
  output logic [2:0]          dbg_state
);
  import obstacle_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_ARMED   = 3'd2,
    S_SETTLE  = 3'd3,
    S_CRASHED = 3'd4
  } state_t;

  state_t             state;
  logic               upd_d;
  logic [1:0]         settle_cnt;
  logic [SLOTS-1:0]   busy_d;
  type_t              typ_r [SLOTS];
  type_t              last_typ;
  logic [1:0]         dup_cnt;
  logic [1:0]         owner;
  logic               owner_vld;

  // Only rnd[1:0] selects the type; the upper bits are deliberately ignored.
  logic [13:0] unused_rnd;
  assign unused_rnd = rnd[15:2];

  assign dbg_state = state;

  for (genvar g = 0; g < SLOTS; g++) begin : g_typ
    assign slot_typ[g*3 +: 3] = typ_r[g];
  end

  // Before any spawn there is no owner, so the divider sees zero.
  assign div_denom = owner_vld ? slot_denom[int'(owner)*11 +: 11] : 11'd0;

  // Clearance of the newest obstacle, as a signed 13-bit sum.
  logic [10:0]        n_x;
  logic [9:0]         n_w;
  logic [10:0]        n_gap;
  logic signed [12:0] clearance;
  logic               want_spawn;
  logic               free_found;
  logic [1:0]         free_idx;
  type_t              cand;
  logic [1:0]         dup_nxt;

  always_comb begin
    n_x       = slot_x_pos[int'(newest)*11 +: 11];
    n_w       = slot_width[int'(newest)*10 +: 10];
    n_gap     = slot_gap[int'(newest)*11 +: 11];
    clearance = $signed({{2{n_x[10]}}, n_x}) + $signed({3'b000, n_w})
              + $signed({2'b00, n_gap});

    // The only case that blocks a spawn is a busy newest obstacle still too
    // close to the right edge; a non-busy newest always lets a spawn through.
    want_spawn = 1'b1;
    if (slot_busy[newest] && (clearance >= 13'(GAME_WIDTH)))
      want_spawn = 1'b0;

    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end

    case (rnd[1:0])
      2'd0, 2'd1: cand = CACTUS_SMALL;
      2'd2:       cand = CACTUS_LARGE;
      default:    cand = PTERODACTYL;
    endcase
    if (cand == PTERODACTYL && speed < 15'(PTERO_MIN_SPEED))
      cand = CACTUS_SMALL;
    if (cand == last_typ && dup_cnt >= 2'(MAX_DUP))
      cand = (cand == CACTUS_SMALL) ? CACTUS_LARGE : CACTUS_SMALL;

    if (cand == last_typ)
      dup_nxt = (dup_cnt >= 2'(MAX_DUP)) ? 2'(MAX_DUP) : dup_cnt + 2'd1;
    else
      dup_nxt = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      upd_d      <= 1'b0;
      settle_cnt <= 2'd0;
      busy_d     <= '0;
      start      <= '0;
      newest     <= 2'd0;
      owner      <= 2'd0;
      owner_vld  <= 1'b0;
      last_typ   <= NONE;
      dup_cnt    <= 2'd0;
      for (int i = 0; i < SLOTS; i++) typ_r[i] <= NONE;
    end else begin
      upd_d  <= update;
      busy_d <= slot_busy;

      // A slot returning to WAITING drops its type. A spawn into the same
      // slot in this cycle is assigned later in this block and wins.
      for (int i = 0; i < SLOTS; i++)
        if (busy_d[i] && !slot_busy[i]) typ_r[i] <= NONE;

      if (crash) begin
        state <= S_CRASHED;
        start <= '0;
      end else begin
        case (state)
          S_IDLE: if (game_start) state <= S_RUN;
          S_RUN: begin
            if (upd_d && want_spawn && free_found) begin
              state           <= S_ARMED;
              start           <= {{(SLOTS-1){1'b0}}, 1'b1} << free_idx;
              typ_r[free_idx] <= cand;
              newest          <= free_idx;
              owner           <= free_idx;
              owner_vld       <= 1'b1;
              last_typ        <= cand;
              dup_cnt         <= dup_nxt;
            end
          end
          S_ARMED: begin
            if (update) begin
              start      <= '0;
              state      <= S_SETTLE;
              settle_cnt <= 2'd0;
            end
          end
          S_SETTLE: begin
            // Three cycles for the slot to init and calculate its gap.
            if (settle_cnt == 2'd2) state <= S_RUN;
            else settle_cnt <= settle_cnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_obstacle_scheduler.sv
module tb_obstacle_scheduler;
  localparam int SLOTS = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                game_start;
  logic                update;
  logic                crash;
  logic [14:0]         speed;
  logic [15:0]         rnd;
  logic [SLOTS-1:0]    slot_busy;
  logic [SLOTS*11-1:0] slot_x_pos;
  logic [SLOTS*10-1:0] slot_width;
  logic [SLOTS*11-1:0] slot_gap;
  logic [SLOTS*11-1:0] slot_denom;
  logic [SLOTS-1:0]    start;
  logic [SLOTS*3-1:0]  slot_typ;
  logic [10:0]         div_denom;
  logic [1:0]          newest;
  logic [2:0]          dbg_state;

  obstacle_scheduler dut (
    .clk(clk), .rst(rst), .game_start(game_start), .update(update),
    .crash(crash), .speed(speed), .rnd(rnd), .slot_busy(slot_busy),
    .slot_x_pos(slot_x_pos), .slot_width(slot_width), .slot_gap(slot_gap),
    .slot_denom(slot_denom), .start(start), .slot_typ(slot_typ),
    .div_denom(div_denom), .newest(newest), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected spawns: {slot[4:3], type[2:0]}
  logic [4:0] exp_q[$];

  // Type codes: 0 NONE, 1 CACTUS_SMALL, 2 CACTUS_LARGE, 3 PTERODACTYL
  // ---------------- reference model state ----------------
  bit running, crashed, armed, owner_vld_m;
  int armed_k, newest_m, owner_m, last_m, dup_m;
  int typ_m[SLOTS];
  bit busy_m[SLOTS];
  int xs[SLOTS], ws[SLOTS], gs[SLOTS], dn[SLOTS];
  int rnd_v, speed_v;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    running = 0; crashed = 0; armed = 0; owner_vld_m = 0;
    armed_k = 0; newest_m = 0; owner_m = 0; last_m = 0; dup_m = 0;
    for (int i = 0; i < SLOTS; i++) begin
      typ_m[i] = 0; busy_m[i] = 0;
      xs[i] = 0; ws[i] = 10; gs[i] = 100; dn[i] = 100 + i;
    end
    rnd_v = 0; speed_v = 4096;
  endtask

  task automatic apply();
    rnd   = 16'(rnd_v);
    speed = 15'(speed_v);
    for (int i = 0; i < SLOTS; i++) begin
      slot_busy[i]            = busy_m[i];
      slot_x_pos[i*11 +: 11]  = 11'(xs[i]);
      slot_width[i*10 +: 10]  = 10'(ws[i]);
      slot_gap[i*11 +: 11]    = 11'(gs[i]);
      slot_denom[i*11 +: 11]  = 11'(dn[i]);
    end
  endtask

  task automatic free_slot(input int k);
    if (busy_m[k]) begin
      busy_m[k] = 0;
      typ_m[k]  = 0;
    end
  endtask

  // Type rule: base map from rnd, no pterodactyls when slow, and a run of
  // more than two identical types is broken.
  task automatic pick_type(input int r, input int spd, output int c);
    case (r % 4)
      0, 1: c = 1;
      2:    c = 2;
      default: c = 3;
    endcase
    if (c == 3 && spd < 8704) c = 1;
    if (c == last_m && dup_m >= 2) c = (c == 1) ? 2 : 1;
    if (c == last_m) dup_m = (dup_m >= 2) ? 2 : dup_m + 1;
    else dup_m = 1;
    last_m = c;
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_start"}, int'(start), armed ? (1 << armed_k) : 0);
    for (int i = 0; i < SLOTS; i++)
      chk($sformatf("%s_typ%0d", tag, i), int'(slot_typ[i*3 +: 3]), typ_m[i]);
    chk({tag, "_newest"}, int'(newest), newest_m);
    chk({tag, "_div_denom"}, int'(div_denom), owner_vld_m ? dn[owner_m] : 0);
  endtask

  // One frame: present inputs, let any slot release settle, tick update,
  // then wait long enough for decision, start and settling to complete.
  task automatic frame(input string tag);
    bit any, want, consume;
    int clr, k, c;
    consume = 0;
    @(negedge clk); apply();
    @(negedge clk);
    if (running && !crashed) begin
      if (armed) consume = 1;
      else begin
        any = 0;
        for (int i = 0; i < SLOTS; i++) any |= busy_m[i];
        clr  = xs[newest_m] + ws[newest_m] + gs[newest_m];
        want = !any || !busy_m[newest_m] || (clr < 640);
        k = -1;
        for (int i = SLOTS - 1; i >= 0; i--) if (!busy_m[i]) k = i;
        if (want && k >= 0) begin
          pick_type(rnd_v, speed_v, c);
          exp_q.push_back({2'(k), 3'(c)});
          typ_m[k] = c; newest_m = k; owner_m = k; owner_vld_m = 1;
          armed = 1; armed_k = k;
        end
      end
    end
    update = 1'b1;
    @(negedge clk); update = 1'b0;
    repeat (7) @(negedge clk);
    if (consume) begin
      armed = 0;
      busy_m[armed_k] = 1;
      apply();
    end
    end_checks(tag);
  endtask

  // ---------------- monitor ----------------
  logic [SLOTS-1:0] prev_start = '0;
  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst && start != '0 && prev_start == '0) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_start: got %b expected no start at %0t", start, $time);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (start != SLOTS'(1 << e[4:3]) || slot_typ[e[4:3]*3 +: 3] != e[2:0]) begin
          failures++;
          $display("FAIL spawn: got start=%b typ=%0d expected slot %0d typ %0d at %0t",
                   start, slot_typ[e[4:3]*3 +: 3], e[4:3], e[2:0], $time);
        end
      end
    end
    prev_start = start;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; game_start = 1'b0; update = 1'b0; crash = 1'b0;
    model_reset();
    apply();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    end_checks("reset");

    // Updates before game_start do nothing.
    frame("idle");

    @(negedge clk); game_start = 1'b1;
    @(negedge clk); game_start = 1'b0;
    running = 1;

    // Empty field, rnd=0: slot 0 gets a small cactus; then it is consumed.
    rnd_v = 0; speed_v = 4096;
    frame("first_spawn");
    frame("first_consume");

    // Newest too close to the edge: 500+17+150 >= 640, no spawn.
    xs[0] = 500; ws[0] = 17; gs[0] = 150;
    frame("no_clear");
    // 400+17+150 < 640: spawn into slot 1.
    xs[0] = 400;
    frame("clear_spawn");
    frame("clear_consume");

    // Slow pterodactyl becomes a small cactus; third small in a row -> large.
    xs[1] = 0; rnd_v = 3; speed_v = 4096;
    frame("slow_ptero");
    frame("slow_consume");

    // All slots busy, clearance met: no spawn. Free slot 1 -> slot 1 spawns.
    xs[2] = 0; rnd_v = 3; speed_v = 9000;
    frame("all_busy");
    free_slot(1);
    frame("free1_spawn");
    frame("free1_consume");

    // Fast pterodactyl.
    free_slot(0);
    rnd_v = 7; speed_v = 9000;
    frame("fast_ptero");
    frame("fast_consume");

    // Randomized frames.
    for (int n = 0; n < 60; n++) begin
      rnd_v = $urandom;
      case ($urandom_range(0, 2))
        0: speed_v = 4096;
        1: speed_v = 9000;
        default: speed_v = $urandom_range(0, 32767);
      endcase
      for (int i = 0; i < SLOTS; i++) begin
        if ($urandom_range(0, 3) == 0) free_slot(i);
        xs[i] = $urandom_range(0, 670) - 20;
        ws[i] = $urandom_range(10, 40);
        gs[i] = $urandom_range(100, 300);
        dn[i] = $urandom_range(0, 2047);
      end
      frame($sformatf("rand%0d", n));
    end

    // Guarantee an armed slot, then crash together with the consuming update.
    if (armed) frame("pre_crash_consume");
    for (int i = 0; i < SLOTS; i++) free_slot(i);
    rnd_v = 2;
    frame("pre_crash_spawn");
    @(negedge clk); crash = 1'b1; update = 1'b1;
    @(negedge clk); crash = 1'b0; update = 1'b0;
    chk("crash_start_clear", int'(start), 0);
    armed = 0; crashed = 1;
    for (int n = 0; n < 3; n++) begin
      rnd_v = $urandom;
      frame($sformatf("crashed%0d", n));
    end

    // Reset returns everything to the reset values.
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    model_reset();
    end_checks("post_rst");
    rst = 1'b0;
    apply();

    // Scheduling works again after reset.
    @(negedge clk); game_start = 1'b1;
    @(negedge clk); game_start = 1'b0;
    running = 1;
    rnd_v = 2;
    frame("restart_spawn");

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
